isa_bus_cycle_engine: RTL
=========================

Name: isa_bus_cycle_engine

Overview:
Parametrised successor to the HPS-to-ISA register bridge.
- Accepts single read/write requests from the HPS side.
- Runs a complete timed ISA I/O cycle: address setup, IOR/IOW strobe with programmable wait states, IOCHRDY extension and hold.
- Returns read data with a done pulse.
- Sits between the HPS Avalon slave glue and the riser's ISA pins. Replaces free-running register loads with a proper cycle state machine.

Parameters:
DATA_W, 16, ISA data bus width (8 or 16)
ADDR_W, 16, ISA I/O address width
SETUP_CYC, 2, clk cycles of address/data valid before strobe (0 allowed)
STROBE_CYC, 8, minimum strobe-active cycles (>=1)
HOLD_CYC, 2, cycles address/write data held after strobe release (0 allowed)
CNT_W, 8, phase counter width; must hold max(SETUP_CYC, STROBE_CYC, HOLD_CYC, TIMEOUT_CYC)
TIMEOUT_CYC, 64, IOCHRDY wait limit; used only with ISA_TIMEOUT_EN

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
req  in  1  HPS request strobe; sampled only when busy=0
wr  in  1  1=write, 0=read; sampled with req
addr_hps_in  in  ADDR_W  request address
data_hps_in  in  DATA_W  write data
data_bus_in  in  DATA_W  ISA data pins, input side
iochrdy  in  1  ISA channel ready, 0 = extend cycle
ior_n  out  1  ISA I/O read strobe, active low
iow_n  out  1  ISA I/O write strobe, active low
address_bus  out  ADDR_W  ISA address
data_bus_out  out  DATA_W  ISA write data
data_bus_oe  out  1  tristate enable for data_bus_out
data_hps_out  out  DATA_W  captured read data
busy  out  1  cycle in progress
done  out  1  one-cycle completion pulse
err  out  1  one-cycle timeout pulse, coincident with done

Behaviour:
- Reset (asserted, async) values: ior_n=1, iow_n=1, address_bus=0, data_bus_out=0, data_bus_oe=0, data_hps_out=0, busy=0, done=0, err=0, state=IDLE. All strobes and outputs release immediately, even mid-cycle. No partial cycle resumes after reset release.
- States: IDLE, SETUP, STROBE, WAIT, HOLD.
- IDLE:
  - On req=1, latch addr, wr and wdata.
  - Next state is SETUP, or STROBE if SETUP_CYC=0.
  - busy=1 from the next cycle.
- SETUP:
  - address_bus valid; data_bus_oe=wr.
  - Strobes inactive for exactly SETUP_CYC cycles.
- STROBE:
  - iow_n=0 if wr, else ior_n=0, for STROBE_CYC cycles.
  - In the last STROBE cycle, iochrdy=0 moves the state to WAIT; otherwise the cycle ends.
- WAIT:
  - Strobe stays asserted while iochrdy=0.
  - The first cycle with iochrdy=1 ends the strobe.
- End of strobe:
  - For a read, data_bus_in is registered into data_hps_out on the edge that deasserts the strobe.
  - data_hps_out is unchanged by writes.
- HOLD:
  - Strobes inactive; address_bus and write data/oe held for HOLD_CYC cycles.
  - data_bus_oe drops on exit from HOLD.
- Completion:
  - Return to IDLE with done=1 for one cycle; busy=0 in that cycle.
  - A new req may be accepted in the same cycle done is high.
- Latency with no wait states: req sampled at edge 0 -> strobe active cycles SETUP_CYC+1 .. SETUP_CYC+STROBE_CYC -> done high in cycle SETUP_CYC+STROBE_CYC+HOLD_CYC+1. Defaults: done in cycle 13.
- Other rules:
  - req while busy=1 is ignored; no queue.
  - ior_n and iow_n are never low simultaneously.
  - address_bus keeps its last value in IDLE.
  - DATA_W=8: only the low byte is used; no byte-lane steering.

Optional Feature:
ISA_TIMEOUT_EN
- Defined:
  - WAIT counts cycles; if iochrdy is still 0 after TIMEOUT_CYC cycles, the strobe releases.
  - For a read, data_hps_out is set to all ones.
  - HOLD proceeds normally; err=1 coincident with done.
- Undefined:
  - WAIT lasts indefinitely; err is tied 0.
  - TIMEOUT_CYC is ignored.

Decomposition:
- Package isa_bus_pkg holds:
  - the state enum (IDLE, SETUP, STROBE, WAIT, HOLD);
  - the ISA strobe-inactive constant (1'b1);
  - the all-ones read-fault value helper.
- One natural sub-module: isa_phase_counter. It is a loadable CNT_W down-counter with a zero flag, shared by SETUP, STROBE, HOLD and timeout counting.

Test Plan:
- Read, defaults, iochrdy=1, data_bus_in=16'hA55A:
  - ior_n low cycles 3..10;
  - data_hps_out=16'hA55A;
  - done in cycle 13; iow_n stays 1.
- Write addr=16'h0220, data=16'h1234:
  - address_bus=0220 and data_bus_oe=1 cycles 1..12;
  - iow_n low cycles 3..10;
  - data_hps_out unchanged.
- IOCHRDY held low 5 extra cycles on a read:
  - ior_n low cycles 3..15; done in cycle 18.
- reset asserted in cycle 6 of a write:
  - iow_n=1 and data_bus_oe=0 immediately; busy=0;
  - no done after release.
- Back-to-back: req held high continuously:
  - second cycle accepted in the done cycle;
  - req pulsed during busy produces no extra cycle.
- ISA_TIMEOUT_EN, TIMEOUT_CYC=4, iochrdy stuck 0 on a read:
  - strobe releases 4 cycles into WAIT;
  - data_hps_out=16'hFFFF; err=1 with done.

Source files
------------

// File: rtl/isa_bus_pkg.sv
// Shared definitions for the ISA bus cycle engine: state encoding, strobe levels and
// the read-fault data pattern.
package isa_bus_pkg;

  // Widest ISA data bus the engine supports.
  localparam int unsigned MaxDataW = 16;

  typedef logic [2:0] isa_state_t;

  localparam isa_state_t StIdle   = 3'd0;
  localparam isa_state_t StSetup  = 3'd1;
  localparam isa_state_t StStrobe = 3'd2;
  localparam isa_state_t StWait   = 3'd3;
  localparam isa_state_t StHold   = 3'd4;

  // ISA IOR#/IOW# are active low.
  localparam logic StrobeOff = 1'b1;

  // Data returned to the HPS when a read is abandoned on an IOCHRDY timeout.
  function automatic logic [MaxDataW-1:0] read_fault_value(input int unsigned width);
    logic [MaxDataW-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MaxDataW; i++) begin
      if (i < width) begin
        v[i] = 1'b1;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/isa_bus_cycle_engine_phase_counter.sv
// Loadable down-counter with a zero flag; times every phase of an ISA cycle.
module isa_phase_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/isa_bus_cycle_engine.sv
// Timed ISA I/O cycle engine: setup, IOR#/IOW# strobe, IOCHRDY extension, hold.
// Define ISA_TIMEOUT_EN to bound IOCHRDY waits to TIMEOUT_CYC cycles and flag err_o.
module isa_bus_cycle_engine
  import isa_bus_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned STROBE_CYC  = 8,
  parameter int unsigned HOLD_CYC    = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] addr_hps_i,
  input  logic [DATA_W-1:0] data_hps_i,
  input  logic [DATA_W-1:0] data_bus_i,
  input  logic              iochrdy_i,
  output logic              ior_n_o,
  output logic              iow_n_o,
  output logic [ADDR_W-1:0] address_bus_o,
  output logic [DATA_W-1:0] data_bus_o,
  output logic              data_bus_oe_o,
  output logic [DATA_W-1:0] data_hps_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  // Counter reload values: a phase of N cycles loads N-1 and ends on the zero flag.
  localparam logic [CNT_W-1:0] SetupLd  = CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] StrobeLd = CNT_W'((STROBE_CYC > 0) ? STROBE_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] HoldLd   = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  isa_state_t        state_q, state_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] data_hps_q, data_hps_d;
  logic              ior_n_q, ior_n_d;
  logic              iow_n_q, iow_n_d;
  logic              oe_q, oe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              strobe_d;
  logic              accept;
  logic              end_strobe;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_ld_val;
  logic              cnt_zero;

`ifdef ISA_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TimeoutLd = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [MaxDataW-1:0] FaultWide = read_fault_value(DATA_W);
  localparam logic [DATA_W-1:0] FaultVal = FaultWide[DATA_W-1:0];

  logic timeout_hit;
  logic err_pend_q, err_pend_d;
  logic err_q, err_d;
`endif

  isa_phase_counter #(
    .Width(CNT_W)
  ) u_phase_counter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (cnt_load),
    .load_val_i (cnt_ld_val),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    cnt_load   = 1'b0;
    cnt_ld_val = '0;
    accept     = 1'b0;
    end_strobe = 1'b0;
    done_d     = 1'b0;
`ifdef ISA_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (req_i) begin
          accept   = 1'b1;
          cnt_load = 1'b1;
          if (SETUP_CYC > 0) begin
            state_d    = StSetup;
            cnt_ld_val = SetupLd;
          end else begin
            state_d    = StStrobe;
            cnt_ld_val = StrobeLd;
          end
        end
      end
      StSetup: begin
        if (cnt_zero) begin
          state_d    = StStrobe;
          cnt_load   = 1'b1;
          cnt_ld_val = StrobeLd;
        end
      end
      StStrobe: begin
        // IOCHRDY is only honoured in the final minimum-strobe cycle.
        if (cnt_zero) begin
          if (!iochrdy_i) begin
            state_d = StWait;
`ifdef ISA_TIMEOUT_EN
            cnt_load   = 1'b1;
            cnt_ld_val = TimeoutLd;
`endif
          end else begin
            end_strobe = 1'b1;
          end
        end
      end
      StWait: begin
        if (iochrdy_i) begin
          end_strobe = 1'b1;
`ifdef ISA_TIMEOUT_EN
        end else if (cnt_zero) begin
          end_strobe  = 1'b1;
          timeout_hit = 1'b1;
`endif
        end
      end
      StHold: begin
        if (cnt_zero) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (end_strobe) begin
      if (HOLD_CYC > 0) begin
        state_d    = StHold;
        cnt_load   = 1'b1;
        cnt_ld_val = HoldLd;
      end else begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
    end
  end

  always_comb begin
    data_hps_d = data_hps_q;
    if (end_strobe && !wr_q) begin
`ifdef ISA_TIMEOUT_EN
      data_hps_d = timeout_hit ? FaultVal : data_bus_i;
`else
      data_hps_d = data_bus_i;
`endif
    end
  end

`ifdef ISA_TIMEOUT_EN
  // A timeout is remembered through HOLD so err lines up with done.
  always_comb begin
    err_d      = done_d & (err_pend_q | timeout_hit);
    err_pend_d = done_d ? 1'b0 : (err_pend_q | timeout_hit);
  end
`endif

  // Pin outputs are registered from the next state so the strobes never glitch.
  always_comb begin
    wr_d     = accept ? wr_i : wr_q;
    strobe_d = (state_d == StStrobe) || (state_d == StWait);
    ior_n_d  = (strobe_d && !wr_d) ? ~StrobeOff : StrobeOff;
    iow_n_d  = (strobe_d && wr_d) ? ~StrobeOff : StrobeOff;
    busy_d   = (state_d != StIdle);
    oe_d     = busy_d && wr_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_hps_q <= '0;
      ior_n_q    <= StrobeOff;
      iow_n_q    <= StrobeOff;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      data_hps_q <= data_hps_d;
      ior_n_q    <= ior_n_d;
      iow_n_q    <= iow_n_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      if (accept) begin
        addr_q  <= addr_hps_i;
        wdata_q <= data_hps_i;
      end
    end
  end

`ifdef ISA_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_pend_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_pend_q <= err_pend_d;
      err_q      <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign ior_n_o       = ior_n_q;
  assign iow_n_o       = iow_n_q;
  assign address_bus_o = addr_q;
  assign data_bus_o    = wdata_q;
  assign data_bus_oe_o = oe_q;
  assign data_hps_o    = data_hps_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule
